fetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of `program_counter`. Reads the PC's `current_address` and issues one instruction-memory read at a time over a req/ack handshake. Buffers returned words in a small FIFO for decode, and drives `next_address` back into the PC: hold, +4, or a redirect target. The PC has no enable, so this block stalls it by returning `current_address` unchanged.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting behind the program counter.
// Issues one instruction-memory read at a time and steers the PC through
// next_address: hold, +4, or a redirect target. Returned words are queued
// in a small FIFO for decode.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   current_address                PC register output
//   next_address                   combinational PC next value
//   imem_req / imem_addr           registered read request / address
//   imem_ack / imem_rdata          read completion and data
//   redirect_valid/redirect_target single-cycle branch/jump redirect
//   if_valid/if_instr/if_pc/if_pc_plus4  FIFO head toward decode
//   if_ready                       decode accepts the head this cycle
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] current_address,
    output logic [ADDR_WIDTH-1:0] next_address,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [ADDR_WIDTH-1:0] if_pc_plus4,
    input  logic                  if_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_imem_req;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];

    logic                  w_ack_now;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_launch;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [ADDR_WIDTH-1:0] w_target_aligned;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign w_target_aligned = redirect_target & ~ADDR_WIDTH'(3);

    // FIFO head toward decode.
    assign if_valid    = (r_count != '0);
    assign if_instr    = r_fifo_instr[r_rd_ptr];
    assign if_pc       = r_fifo_pc[r_rd_ptr];
    assign if_pc_plus4 = if_pc + ADDR_WIDTH'(4);
    assign imem_req    = r_imem_req;
    assign imem_addr   = r_req_addr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, launch decision and PC steering.
    always_comb begin
        w_state_next = r_state;
        w_ack_now    = imem_ack && (r_state != S_IDLE);
        w_pop        = if_valid && if_ready;
        w_push       = w_ack_now && (r_state == S_BUSY) && !redirect_valid;
        w_cnt_next   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        // Only launch when the word it returns is guaranteed a FIFO slot.
        w_launch     = ((r_state == S_IDLE) || ((r_state == S_BUSY) && w_ack_now))
                       && (w_cnt_next < CNT_W'(FIFO_DEPTH)) && !redirect_valid;
        next_address = current_address;

        if (reset) begin
            next_address = '0;
        end else if (redirect_valid) begin
            next_address = w_target_aligned;
        end else if (w_launch) begin
            next_address = current_address + ADDR_WIDTH'(4);
        end

        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // A redirect kills the outstanding read; wait it out in DRAIN.
                if (redirect_valid) begin
                    w_state_next = w_ack_now ? S_IDLE : S_DRAIN;
                end else if (w_ack_now) begin
                    w_state_next = w_launch ? S_BUSY : S_IDLE;
                end
            end
            S_DRAIN: begin
                // The stale read must complete before anything new is issued.
                if (w_ack_now) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request register and fetch queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_imem_req <= 1'b0;
            r_req_addr <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else begin
            r_imem_req <= (w_state_next != S_IDLE);
            if (w_launch) begin
                r_req_addr <= current_address;
            end
            if (redirect_valid) begin
                // Flush; a head popped this cycle was already consumed by decode.
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_count <= w_cnt_next;
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= imem_rdata;
                    r_fifo_pc[r_wr_ptr]    <= r_req_addr;
                    r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behaves as the PC register and the instruction
// memory, and checks the fetch stream against a transaction-level model.
module tb_fetch_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] current_address;
    logic [AW-1:0] next_address;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pc_plus4;
    logic          if_ready;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    // Model: queue of fetch addresses decode should see, plus the open read.
    logic [AW-1:0] q[$];
    bit            in_txn;
    bit            txn_dead;
    bit            expect_launch;
    logic [AW-1:0] txn_addr;
    logic [AW-1:0] exp_fetch;
    logic [AW-1:0] nxt_s;

    // Memory behaviour.
    bit mem_open;
    int wait_left;
    int lat_q[$];
    int lat_max;
    bit garbage;

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .current_address (current_address),
        .next_address    (next_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_ready        (if_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs at the falling edge: check outputs, then advance the model by the
    // effects of the coming rising edge.
    task automatic model_step();
        bit            pop;
        bit            new_txn;
        logic [AW-1:0] tgt;
        logic [AW-1:0] e4;
        nxt_s = next_address;
        if (reset) begin
            chk("rst_req", imem_req, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_valid", if_valid, 0);
            chk("rst_instr", if_instr, 0);
            chk("rst_pc", if_pc, 0);
            chk("rst_pc4", if_pc_plus4, 4);
            chk("rst_next", next_address, 0);
            q.delete();
            in_txn = 0; txn_dead = 0; expect_launch = 0; exp_fetch = '0;
            return;
        end
        chk("valid", if_valid, q.size() != 0);
        if (q.size() != 0) begin
            e4 = q[0] + AW'(4);
            chk("head_pc", if_pc, q[0]);
            chk("head_instr", if_instr, mem_word(q[0]));
            chk("head_pc4", if_pc_plus4, e4);
        end
        new_txn = imem_req && !in_txn;
        chk("launch", new_txn, expect_launch);
        if (in_txn) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, txn_addr);
        end
        if (new_txn) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            chk("room", q.size() < DEPTH, 1);
            exp_fetch = imem_addr + AW'(4);
            in_txn = 1; txn_addr = imem_addr; txn_dead = 0;
        end
        pop = (q.size() != 0) && if_ready;
        tgt = {redirect_target[AW-1:2], 2'b00};
        if (redirect_valid) begin
            chk("next_redirect", next_address, tgt);
            if (in_txn) txn_dead = 1;
            expect_launch = 0;
        end else begin
            chk("next_step", (next_address === current_address) ||
                             (next_address === current_address + AW'(4)), 1);
            expect_launch = (next_address === current_address + AW'(4));
        end
        if (pop) begin
            void'(q.pop_front());
            pops++;
        end
        if (in_txn && imem_ack && !txn_dead) begin
            q.push_back(txn_addr);
            chk("no_overflow", q.size() <= DEPTH, 1);
        end
        if (in_txn && imem_ack) in_txn = 0;
        if (redirect_valid) begin
            q.delete();
            exp_fetch = tgt;
        end
    endtask

    task automatic mem_drive();
        if (mem_open && imem_ack) mem_open = 0;
        if (!imem_req) begin
            mem_open   = 0;
            imem_ack   = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = $urandom;
        end else begin
            if (!mem_open) begin
                mem_open  = 1;
                wait_left = (lat_q.size() != 0) ? lat_q.pop_front()
                                                : int'($urandom_range(0, lat_max));
            end
            imem_ack = (wait_left == 0);
            if (wait_left > 0) wait_left--;
            imem_rdata = mem_word(imem_addr);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        current_address = nxt_s;
        mem_drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        lat_q.delete();
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        bit ok;
        bit found;
        int n4;
        int p0;
        reset = 1'b1; current_address = '0; imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_target = '0; if_ready = 1'b1;
        garbage = 0; lat_max = 0; mem_open = 0; wait_left = 0;

        // Zero-wait memory, decode always ready.
        do_reset();
        chk("a_valid_k0", if_valid, 0);
        tick();
        chk("a_req_k1", imem_req, 1);
        chk("a_addr_k1", imem_addr, 0);
        chk("a_valid_k1", if_valid, 0);
        chk("a_pcreg_k1", current_address, 4);
        tick();
        chk("a_valid_k2", if_valid, 1);
        chk("a_pc_k2", if_pc, 0);
        chk("a_pcreg_k2", current_address, 8);
        tick();
        chk("a_pc_k3", if_pc, 4);
        chk("a_instr_k3", if_instr, mem_word(32'h4));
        tick();
        chk("a_pc_k4", if_pc, 8);
        ok = 1;
        repeat (8) begin tick(); ok &= if_valid; end
        chk("a_stream", ok, 1);

        // Decode stalled: FIFO fills, PC holds.
        if_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        chk("b_req_low", imem_req, 0);
        chk("b_pc_hold", current_address, 8);
        chk("b_head", if_pc, 0);
        chk("b_valid", if_valid, 1);
        if_ready = 1'b1;
        tick();
        chk("b_head2", if_pc, 4);
        chk("b_req8", imem_req, 1);
        chk("b_addr8", imem_addr, 8);
        repeat (4) tick();

        // Slow read on 0x4.
        do_reset();
        lat_q.push_back(0); lat_q.push_back(3);
        n4 = 0;
        repeat (10) begin
            tick();
            if (imem_req && imem_addr == 32'h4 && current_address == 32'h8) n4++;
        end
        chk("c_hold4", n4, 4);

        // Redirect while the read of 0x8 is outstanding.
        do_reset();
        lat_q.push_back(0); lat_q.push_back(0); lat_q.push_back(5);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h8) begin found = 1; break; end
        end
        chk("d_found8", found, 1);
        chk("d_noack", imem_ack, 0);
        redirect_valid = 1'b1; redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("d_valid0", if_valid, 0);
        chk("d_drain_req", imem_req, 1);
        chk("d_drain_addr", imem_addr, 8);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h100) begin found = 1; break; end
        end
        chk("d_fetch100", found, 1);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_valid) begin found = 1; break; end
        end
        chk("d_valid100", found, 1);
        chk("d_pc100", if_pc, 32'h100);

        // Redirect coinciding with ack, then wrap at the top of memory.
        do_reset();
        repeat (3) tick();
        chk("e_busy_ack", imem_req && imem_ack, 1);
        redirect_valid = 1'b1; redirect_target = 32'h103;
        tick();
        redirect_valid = 1'b0;
        chk("e_idle", imem_req, 0);
        chk("e_valid0", if_valid, 0);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h100) begin found = 1; break; end
        end
        chk("e_fetch100", found, 1);
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_valid && if_pc == 32'hFFFF_FFFC) begin found = 1; break; end
        end
        chk("e_top", found, 1);
        chk("e_pc4_wrap", if_pc_plus4, 0);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_valid && if_pc == 32'h0) begin found = 1; break; end
        end
        chk("e_wrap0", found, 1);

        // Reset asserted between edges during an outstanding read.
        do_reset();
        lat_q.push_back(0); lat_q.push_back(6);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h4) begin found = 1; break; end
        end
        chk("f_busy4", found, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("f_req", imem_req, 0);
        chk("f_valid", if_valid, 0);
        chk("f_addr", imem_addr, 0);
        chk("f_next", next_address, 0);
        chk("f_pc4", if_pc_plus4, 4);
        repeat (2) tick();
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_valid && if_pc == 32'h0) begin found = 1; break; end
        end
        chk("f_restart0", found, 1);

        // Random traffic.
        do_reset();
        garbage = 1; lat_max = 3;
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            if_ready        = ($urandom_range(0, 9) < 7);
            redirect_valid  = ($urandom_range(0, 99) < 4);
            redirect_target = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        tick();
        chk("g_progress", (pops - p0) > 200, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
